// File: rtl/parc_dmem_responder.sv
// parc_dmem_responder
//   Memory-side responder for the core data-memory val/rdy port. It holds a
//   word-organised SRAM model, applies subword writes, and returns
//   right-justified subword reads in request order after a fixed latency.
//   Sign/zero extension is left to the core.
//
// Parameters
//   SIZE_BYTES  memory capacity in bytes (power of two, >= 4)
//   LATENCY     cycles from the request accept edge to memresp_val (1..4)
//
// Ports
//   clk                 clock, all state changes on posedge
//   reset               asynchronous active-low reset (0 = in reset)
//   memreq_val/rdy      request handshake
//   memreq_msg_type     0 = read, 1 = write
//   memreq_msg_addr     byte address; upper bits beyond SIZE_BYTES ignored
//   memreq_msg_len      0 = word, 1 = byte, 2 = halfword, 3 = illegal
//   memreq_msg_data     right-justified write data
//   memresp_val/rdy     response handshake
//   memresp_msg_type    echoed request type
//   memresp_msg_len     echoed request len
//   memresp_msg_data    right-justified read data, 0 for writes/bad requests
//   align_err           sticky flag: misaligned or len==3 request accepted
//
// Optional build macro PARC_DMEM_RESPONDER_STATS_EN adds num_reads,
// num_writes and stall_cycles counters as outputs.
module parc_dmem_responder #(
  parameter int unsigned SIZE_BYTES = 65536,
  parameter int unsigned LATENCY    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreq_val,
  output logic        memreq_rdy,
  input  logic        memreq_msg_type,
  input  logic [31:0] memreq_msg_addr,
  input  logic [1:0]  memreq_msg_len,
  input  logic [31:0] memreq_msg_data,
  output logic        memresp_val,
  input  logic        memresp_rdy,
  output logic        memresp_msg_type,
  output logic [1:0]  memresp_msg_len,
  output logic [31:0] memresp_msg_data,
  output logic        align_err
`ifdef PARC_DMEM_RESPONDER_STATS_EN
  ,
  output logic [31:0] num_reads,
  output logic [31:0] num_writes,
  output logic [31:0] stall_cycles
`endif
);

  localparam int unsigned AW    = $clog2(SIZE_BYTES);
  localparam int unsigned WORDS = SIZE_BYTES / 4;
  localparam int unsigned IW    = (AW > 2) ? AW - 2 : 1;
  localparam int unsigned DEPTH = LATENCY + 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned PW    = $clog2(DEPTH);

  typedef enum logic [1:0] {
    LEN_WORD = 2'd0,
    LEN_BYTE = 2'd1,
    LEN_HALF = 2'd2,
    LEN_BAD  = 2'd3
  } len_e;

  // ---------------------------------------------------------------------
  // Request decode and array access
  // ---------------------------------------------------------------------
  logic [31:0] mem_q [WORDS];

  logic [IW-1:0] idx;
  len_e          req_len;
  logic          accept;
  logic          misalign;
  logic [31:0]   rd_word;
  logic [31:0]   rd_data;
  logic [31:0]   wr_word;
  logic [31:0]   resp_data;
  logic [4:0]    byte_sh;
  logic [4:0]    half_sh;

  generate
    if (AW > 2) begin : g_idx
      assign idx = memreq_msg_addr[AW-1:2];
    end else begin : g_idx_one
      assign idx = '0;
    end
  endgenerate

  logic unused_addr;
  assign unused_addr = ^memreq_msg_addr[31:AW];

  assign req_len = len_e'(memreq_msg_len);
  assign accept  = memreq_val & memreq_rdy;
  assign rd_word = mem_q[idx];
  assign byte_sh = {memreq_msg_addr[1:0], 3'b000};
  assign half_sh = {memreq_msg_addr[1], 4'b0000};

  always_comb begin
    misalign = 1'b0;
    rd_data  = '0;
    wr_word  = rd_word;
    case (req_len)
      LEN_WORD: begin
        misalign = |memreq_msg_addr[1:0];
        rd_data  = rd_word;
        wr_word  = memreq_msg_data;
      end
      LEN_BYTE: begin
        rd_data[7:0]           = rd_word[byte_sh +: 8];
        wr_word[byte_sh +: 8]  = memreq_msg_data[7:0];
      end
      LEN_HALF: begin
        misalign               = memreq_msg_addr[0];
        rd_data[15:0]          = rd_word[half_sh +: 16];
        wr_word[half_sh +: 16] = memreq_msg_data[15:0];
      end
      default: misalign = 1'b1;
    endcase
    resp_data = (memreq_msg_type || misalign) ? '0 : rd_data;
  end

  // Array is never reset; writes are gated by accept, which is low in reset.
  always_ff @(posedge clk) begin
    if (accept && memreq_msg_type && !misalign) begin
      mem_q[idx] <= wr_word;
    end
  end

  // ---------------------------------------------------------------------
  // Latency pipeline
  // ---------------------------------------------------------------------
  logic        pipe_val_q  [LATENCY];
  logic        pipe_type_q [LATENCY];
  logic [1:0]  pipe_len_q  [LATENCY];
  logic [31:0] pipe_data_q [LATENCY];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe_val_q[i]  <= 1'b0;
        pipe_type_q[i] <= 1'b0;
        pipe_len_q[i]  <= '0;
        pipe_data_q[i] <= '0;
      end
    end else begin
      pipe_val_q[0]  <= accept;
      pipe_type_q[0] <= memreq_msg_type;
      pipe_len_q[0]  <= memreq_msg_len;
      pipe_data_q[0] <= resp_data;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_val_q[i]  <= pipe_val_q[i-1];
        pipe_type_q[i] <= pipe_type_q[i-1];
        pipe_len_q[i]  <= pipe_len_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output FIFO and credit counter
  // ---------------------------------------------------------------------
  logic        fifo_type_q [DEPTH];
  logic [1:0]  fifo_len_q  [DEPTH];
  logic [31:0] fifo_data_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy_en_q;
  logic          err_q;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push = pipe_val_q[LATENCY-1];
  assign pop  = memresp_val & memresp_rdy;

  // The pipeline never stalls: a request only enters once it holds a credit,
  // and credits cover pipeline plus FIFO, so the FIFO always has room.
  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fcnt_d   = fcnt_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_type_q[i] <= 1'b0;
        fifo_len_q[i]  <= '0;
        fifo_data_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      cnt_q    <= '0;
      rdy_en_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (push) begin
        fifo_type_q[wr_ptr_q] <= pipe_type_q[LATENCY-1];
        fifo_len_q[wr_ptr_q]  <= pipe_len_q[LATENCY-1];
        fifo_data_q[wr_ptr_q] <= pipe_data_q[LATENCY-1];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= 1'b1;
      if (accept && misalign) begin
        err_q <= 1'b1;
      end
    end
  end

  // rdy depends only on registered state, never on memresp_rdy.
  assign memreq_rdy       = rdy_en_q & (cnt_q < CW'(DEPTH));
  assign memresp_val      = (fcnt_q != '0);
  assign memresp_msg_type = memresp_val ? fifo_type_q[rd_ptr_q] : 1'b0;
  assign memresp_msg_len  = memresp_val ? fifo_len_q[rd_ptr_q]  : 2'b00;
  assign memresp_msg_data = memresp_val ? fifo_data_q[rd_ptr_q] : '0;
  assign align_err        = err_q;

`ifdef PARC_DMEM_RESPONDER_STATS_EN
  logic [31:0] num_reads_q;
  logic [31:0] num_writes_q;
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_reads_q    <= '0;
      num_writes_q   <= '0;
      stall_cycles_q <= '0;
    end else begin
      if (accept && !memreq_msg_type) begin
        num_reads_q <= num_reads_q + 32'd1;
      end
      if (accept && memreq_msg_type) begin
        num_writes_q <= num_writes_q + 32'd1;
      end
      if (memresp_val && !memresp_rdy) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
    end
  end

  assign num_reads    = num_reads_q;
  assign num_writes   = num_writes_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_parc_dmem_responder.sv
// tb_parc_dmem_responder
//   Scoreboard bench for parc_dmem_responder (SIZE_BYTES=65536, LATENCY=2).
//   Expected responses are queued when a request is accepted and compared in
//   order as the DUT hands them over.
module tb_parc_dmem_responder;

  logic        clk;
  logic        reset;
  logic        memreq_val;
  logic        memreq_rdy;
  logic        memreq_msg_type;
  logic [31:0] memreq_msg_addr;
  logic [1:0]  memreq_msg_len;
  logic [31:0] memreq_msg_data;
  logic        memresp_val;
  logic        memresp_rdy;
  logic        memresp_msg_type;
  logic [1:0]  memresp_msg_len;
  logic [31:0] memresp_msg_data;
  logic        align_err;
`ifdef PARC_DMEM_RESPONDER_STATS_EN
  logic [31:0] num_reads;
  logic [31:0] num_writes;
  logic [31:0] stall_cycles;
`endif

  parc_dmem_responder #(
    .SIZE_BYTES(65536),
    .LATENCY   (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .memreq_val      (memreq_val),
    .memreq_rdy      (memreq_rdy),
    .memreq_msg_type (memreq_msg_type),
    .memreq_msg_addr (memreq_msg_addr),
    .memreq_msg_len  (memreq_msg_len),
    .memreq_msg_data (memreq_msg_data),
    .memresp_val     (memresp_val),
    .memresp_rdy     (memresp_rdy),
    .memresp_msg_type(memresp_msg_type),
    .memresp_msg_len (memresp_msg_len),
    .memresp_msg_data(memresp_msg_data),
    .align_err       (align_err)
`ifdef PARC_DMEM_RESPONDER_STATS_EN
    ,
    .num_reads       (num_reads),
    .num_writes      (num_writes),
    .stall_cycles    (stall_cycles)
`endif
  );

  typedef struct packed {
    logic        t;
    logic [1:0]  l;
    logic [31:0] d;
  } resp_t;

  resp_t sb[$];
  resp_t mon_e;
  int    n_tests = 0;
  int    n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: a response is consumed at the posedge following this sample.
  always @(negedge clk) begin
    if (reset && memresp_val && memresp_rdy) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("resp_type", 32'(memresp_msg_type), 32'(mon_e.t));
        check("resp_len",  32'(memresp_msg_len),  32'(mon_e.l));
        check("resp_data", memresp_msg_data,      mon_e.d);
      end
    end
  end

  task automatic send(input logic t, input logic [31:0] a, input logic [1:0] l,
                      input logic [31:0] d, input logic [31:0] exp_data);
    int unsigned waited;
    resp_t e;
    waited          = 0;
    memreq_val      = 1'b1;
    memreq_msg_type = t;
    memreq_msg_addr = a;
    memreq_msg_len  = l;
    memreq_msg_data = d;
    @(negedge clk);
    while (!memreq_rdy && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!memreq_rdy) begin
      check("req_timeout", 32'(waited), 32'd0);
      memreq_val = 1'b0;
    end else begin
      e.t = t;
      e.l = l;
      e.d = exp_data;
      sb.push_back(e);
      @(posedge clk);
      #1;
      memreq_val = 1'b0;
    end
  endtask

  task automatic wait_drain(input string tag);
    int unsigned c;
    c = 0;
    while (sb.size() != 0 && c < 50) begin
      @(posedge clk);
      c++;
    end
    #1;
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    int unsigned c;
    resp_t e;

    reset           = 1'b0;
    memreq_val      = 1'b0;
    memreq_msg_type = 1'b0;
    memreq_msg_addr = '0;
    memreq_msg_len  = '0;
    memreq_msg_data = '0;
    memresp_rdy     = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_rdy",   32'(memreq_rdy),  32'd0);
    check("rst_resp_val",  32'(memresp_val), 32'd0);
    check("rst_resp_data", memresp_msg_data, 32'd0);
    check("rst_align_err", 32'(align_err),   32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rel_rdy_low", 32'(memreq_rdy), 32'd0);
    @(posedge clk);
    #1;
    check("rel_rdy_high", 32'(memreq_rdy), 32'd1);

    // Word write / read
    send(1'b1, 32'h100, 2'd0, 32'hDEADBEEF, 32'h0);
    send(1'b0, 32'h100, 2'd0, 32'h0,        32'hDEADBEEF);

    // Subword write and reads
    send(1'b1, 32'h101, 2'd1, 32'h0000005A, 32'h0);
    send(1'b0, 32'h101, 2'd1, 32'h0,        32'h0000005A);
    send(1'b0, 32'h100, 2'd2, 32'h0,        32'h00005AEF);
    send(1'b0, 32'h100, 2'd0, 32'h0,        32'hDEAD5AEF);
    wait_drain("drain_basic");

    // Misaligned / illegal requests
    check("align_err_clear", 32'(align_err), 32'd0);
    send(1'b0, 32'h103, 2'd2, 32'h0, 32'h0);
    wait_drain("drain_misalign");
    check("align_err_set", 32'(align_err), 32'd1);
    send(1'b0, 32'h000, 2'd3, 32'h0,        32'h0);
    send(1'b1, 32'h102, 2'd0, 32'h11111111, 32'h0);
    send(1'b0, 32'h100, 2'd0, 32'h0,        32'hDEAD5AEF);

    // Upper halfword write and lane reads
    send(1'b1, 32'h102, 2'd2, 32'h0000BEEF, 32'h0);
    send(1'b0, 32'h100, 2'd0, 32'h0,        32'hBEEF5AEF);
    send(1'b0, 32'h103, 2'd1, 32'h0,        32'h000000BE);
    send(1'b0, 32'h102, 2'd2, 32'h0,        32'h0000BEEF);

    // Address wrap modulo SIZE_BYTES
    send(1'b1, 32'h00010004, 2'd0, 32'hCAFEF00D, 32'h0);
    send(1'b0, 32'h00000004, 2'd0, 32'h0,        32'hCAFEF00D);

    // Preload for backpressure run
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 32'h200 + 32'(4 * i), 2'd0, 32'hA0A00000 + 32'(i), 32'h0);
    end
    wait_drain("drain_preload");
    check("align_err_sticky", 32'(align_err), 32'd1);

    // Unloaded latency: accept at edge N, valid after edge N+2
    send(1'b0, 32'h200, 2'd0, 32'h0, 32'hA0A00000);
    @(negedge clk);
    check("lat_val_n0", 32'(memresp_val), 32'd0);
    @(negedge clk);
    check("lat_val_n1", 32'(memresp_val), 32'd0);
    @(negedge clk);
    check("lat_val_n2", 32'(memresp_val), 32'd1);
    wait_drain("drain_latency");

    // Backpressure: 5 reads streamed with memresp_rdy low
    memresp_rdy     = 1'b0;
    k               = 0;
    memreq_val      = 1'b1;
    memreq_msg_type = 1'b0;
    memreq_msg_len  = 2'd0;
    memreq_msg_addr = 32'h200;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (memreq_val && memreq_rdy) begin
        e.t = 1'b0;
        e.l = 2'd0;
        e.d = 32'hA0A00000 + 32'(k);
        sb.push_back(e);
        k++;
      end
      @(posedge clk);
      #1;
      if (k < 5) memreq_msg_addr = 32'h200 + 32'(4 * k);
      else       memreq_val = 1'b0;
    end
    check("bp_accepted", 32'(k), 32'd3);
    check("bp_req_rdy",  32'(memreq_rdy),       32'd0);
    check("bp_hold_val", 32'(memresp_val),      32'd1);
    check("bp_hold_dat", memresp_msg_data,      32'hA0A00000);
    memresp_rdy = 1'b1;
    c = 0;
    while (k < 5 && c < 20) begin
      @(negedge clk);
      if (memreq_val && memreq_rdy) begin
        e.t = 1'b0;
        e.l = 2'd0;
        e.d = 32'hA0A00000 + 32'(k);
        sb.push_back(e);
        k++;
      end
      @(posedge clk);
      #1;
      c++;
      if (k < 5) memreq_msg_addr = 32'h200 + 32'(4 * k);
      else       memreq_val = 1'b0;
    end
    memreq_val = 1'b0;
    check("bp_total_accepted", 32'(k), 32'd5);
    wait_drain("drain_bp");

    // Reset with two requests in flight
    memresp_rdy = 1'b0;
    send(1'b0, 32'h100, 2'd0, 32'h0, 32'hBEEF5AEF);
    send(1'b0, 32'h004, 2'd0, 32'h0, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    check("pre_rst_val", 32'(memresp_val), 32'd1);
    reset = 1'b0;
    #1;
    check("rst2_resp_val",  32'(memresp_val), 32'd0);
    check("rst2_req_rdy",   32'(memreq_rdy),  32'd0);
    check("rst2_resp_data", memresp_msg_data, 32'd0);
    check("rst2_align_err", 32'(align_err),   32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    memresp_rdy = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("rst2_no_stale", 32'(memresp_val), 32'd0);
    send(1'b0, 32'h100, 2'd0, 32'h0, 32'hBEEF5AEF);
    send(1'b0, 32'h004, 2'd0, 32'h0, 32'hCAFEF00D);
    wait_drain("drain_final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
